// File: rtl/inst_fetch_queue_if.sv
// Bundles the redirect, memory request/response and decode-side signals of inst_fetch_queue.
// fsm_state is a debug view of the fetch FSM (BOOT=0, RUN=1, HALT=2).
interface inst_fetch_queue_if;
  // Handshakes: a request transfers on a clock edge where mem_req_valid && mem_req_ready,
  // and an instruction transfers where inst_valid && inst_ready. The response channel has
  // no ready: mem_rsp_valid marks one in-order response per accepted request.
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        fetch_fault;
  logic [1:0]  fsm_state;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault, fsm_state
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault, fsm_state
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential/redirected PC reads and buffers returned words for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises fetch_fault.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1
`ifdef FETCH_MISALIGN_TRAP_EN
    , HALT = 2'd2
`endif
  } state_t;

  state_t        state;
  logic [63:0]   fetch_pc;
  logic [63:0]   rsp_pc;
  logic [31:0]   q_data [DEPTH];
  logic [63:0]   q_pc   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic          run;
  logic          redirect;
  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_next;
  logic [63:0]   target;

  // Outstanding requests plus queued words never exceed DEPTH, so a push always finds room.
  assign run              = (state == RUN);
  assign redirect         = run && bus.redirect_valid;
  assign credit_ok        = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(DEPTH);
  assign req_valid        = run && !bus.redirect_valid && credit_ok;
  assign req_fire         = req_valid && bus.mem_req_ready;
  assign push             = bus.mem_rsp_valid && (drop_cnt == '0);
  assign pop              = (count != '0) && bus.inst_ready;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(bus.mem_rsp_valid);
  assign target           = bus.redirect_pc & ~64'd3;

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = fetch_pc;
  assign bus.inst_valid    = (count != '0);
  assign bus.inst_data     = q_data[rd_ptr];
  assign bus.inst_pc       = q_pc[rd_ptr];
  assign bus.fsm_state     = state;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault;
  assign bus.fetch_fault = fault;
`else
  assign bus.fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      fault       <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding_next;
      if (state == BOOT) state <= RUN;
      if (redirect) begin
        // Everything in flight belongs to the old path, including a response arriving now.
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        drop_cnt <= outstanding_next;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (bus.redirect_pc[1:0] != 2'b00) begin
          state <= HALT;
          fault <= 1'b1;
        end else begin
          fetch_pc <= target;
          rsp_pc   <= target;
        end
`else
        fetch_pc <= target;
        rsp_pc   <= target;
`endif
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (bus.mem_rsp_valid) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            q_data[wr_ptr] <= bus.mem_rsp_data;
            q_pc[wr_ptr]   <= rsp_pc;
            wr_ptr         <= wr_ptr + PW'(1);
            rsp_pc         <= rsp_pc + 64'd4;
          end
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push && !redirect && (count == CW'(DEPTH))));
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Consumer side of the PC path: takes the PC sequence (sequential +4 or branch redirect) and turns it into instruction-memory read requests.
- Buffers returned instruction words with their PCs in a small in-order queue and hands them to decode with a valid/ready handshake.
- Sits between the PC/branch-target logic and the decoder. A redirect flushes the queue and discards responses still in flight.

Parameters:
- DEPTH, 4, queue entries; also the maximum number of outstanding memory requests (power of 2, at least 2).
- RESET_PC, 64'd0, fetch PC loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch taken; load redirect_pc this cycle.
- redirect_pc  in  64  branch target (PC + shifted immediate).
- mem_req_valid  out  1  read request valid.
- mem_req_addr  out  64  request address, equal to the fetch PC.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  read data returned. Responses come in order, one per accepted request, at least 1 cycle after acceptance.
- mem_rsp_data  in  32  instruction word.
- inst_valid  out  1  queue head valid.
- inst_data  out  32  head instruction.
- inst_pc  out  64  head PC.
- inst_ready  in  1  decoder consumes the head.
- fetch_fault  out  1  misaligned-redirect fault, only meaningful with the optional feature.

Behaviour:
- Reset (asynchronous, all outputs): fetch_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, state=BOOT, mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0.
- Reset asserted mid-operation clears everything immediately. Responses arriving after reset releases are not expected; the memory is reset with the same signal.
- FSM transitions:
  - BOOT -> RUN unconditionally on the first clock after reset deasserts. No request is issued in BOOT.
  - RUN -> HALT only with the optional feature.
- Request issue:
  - In RUN, mem_req_valid=1 iff (outstanding + queue_count) < DEPTH and redirect_valid=0.
  - mem_req_addr=fetch_pc, combinationally from the register.
  - Accepted when valid && ready. On accept: fetch_pc <= fetch_pc + 4 (64-bit wrap, carry dropped) and outstanding increments.
- Responses:
  - Memory responses are always accepted; there is no backpressure on the response channel.
  - When mem_rsp_valid=1, outstanding decrements.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {rsp_pc, mem_rsp_data} is pushed into the queue. rsp_pc is a separate register holding the PC of the oldest live request; it starts at the fetch_pc at redirect/reset and increments by 4 per pushed response.
  - The credit rule guarantees no overflow. A push into a full queue is an assertion failure.
- Queue:
  - inst_valid = count>0; the head fields are registered queue outputs.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Latency: a response is visible at the head 1 cycle after mem_rsp_valid when the queue was empty.
- Redirect (RUN, redirect_valid=1), all effective at the next edge:
  - The queue is flushed (count=0, pointers reset). A same-cycle pop is ignored.
  - fetch_pc <= redirect_pc and rsp_pc <= redirect_pc.
  - drop_cnt <= outstanding_next, i.e. outstanding after this cycle's response decrement. If a response arrives in the redirect cycle it is itself discarded.
  - No request is issued in the redirect cycle.
- Redirect priority: redirect overrides sequential increment, push and pop in the same cycle.
- Back-to-back redirects: each one reloads fetch_pc; only the last redirect's target is fetched.
- Alignment (macro absent): redirect_pc[1:0] is forced to 2'b00 when loaded.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0]!=0 moves the FSM to HALT.
  - Sets fetch_fault=1 (sticky until reset) and flushes the queue.
  - drop_cnt handling is the same as for a normal redirect.
  - In HALT no requests are issued and further redirects are ignored.
- Undefined: no HALT state; fetch_fault is tied to 0; low bits are cleared as described in Behaviour.

Test Plan:
- Reset then run with mem_req_ready=1, 1-cycle response latency, inst_ready=1 -> first request in cycle 2 (after BOOT) at 0x0. inst_pc sequence 0x0, 0x4, 0x8, 0xC with matching data.
- inst_ready=0, memory always ready -> exactly 4 requests issued (0x0-0xC), then mem_req_valid=0. Queue count=4. Releasing inst_ready resumes at 0x10.
- 3 requests outstanding (response latency 5), redirect to 0x100 -> 3 responses discarded. Next inst_pc=0x100. mem_req_addr=0x100 the cycle after the redirect.
- Redirect in the same cycle as a response and a pop, target 0x40 -> that response is dropped, the queue is empty next cycle, and the first delivered instruction has inst_pc=0x40.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC accepted -> next mem_req_addr=0x0 (wrap).
- Redirect to 0x102: macro off -> fetch at 0x100. Macro on -> fetch_fault=1, mem_req_valid stays 0 until reset.
